// File: rtl/alu_arb_pkg.sv
// Shared definitions for the EXE-stage ALU arbiter: command codes, status bit
// positions, requester count and the SR-update command filter.
package alu_arb_pkg;

   localparam int NUM_REQ = 2;

   localparam logic [3:0] CMD_NOP = 4'b0000;
   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   localparam int SR_Z = 3;
   localparam int SR_C = 2;
   localparam int SR_N = 1;
   localparam int SR_V = 0;

   // NOP and undefined codes never touch SR, even with the S bit set.
   function automatic logic cmd_sets_sr(input logic [3:0] cmd);
      case (cmd)
         CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB,
         CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR: cmd_sets_sr = 1'b1;
         default:                            cmd_sets_sr = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with pointer state; optional grant lock when
// built with ALU_ARB_LOCK_EN.
module rr_arbiter2
   import alu_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [NUM_REQ-1:0] i_lock,
   input  logic               i_can_accept,
   output logic [NUM_REQ-1:0] o_grant,
   output logic               o_ptr,
   output logic               o_fire
);

   logic               r_ptr;
   logic [NUM_REQ-1:0] w_grant;
   logic               w_id;
   logic               w_fire;

`ifdef ALU_ARB_LOCK_EN
   logic r_locked;
   logic r_lock_id;
`else
   logic w_unused_lock;
   assign w_unused_lock = ^i_lock;
`endif

   always_comb begin
      w_grant = 2'b00;
      case (i_valid)
         2'b01:   w_grant = 2'b01;
         2'b10:   w_grant = 2'b10;
         2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
         default: w_grant = 2'b00;
      endcase
`ifdef ALU_ARB_LOCK_EN
      if (r_locked) w_grant = r_lock_id ? 2'b10 : 2'b01;
`endif
   end

   assign w_id   = w_grant[1];
   assign w_fire = (|(w_grant & i_valid)) & i_can_accept;

   // Pointer moves to the other requester only on a real transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ptr <= 1'b0;
      else if (w_fire) r_ptr <= ~w_id;
   end

`ifdef ALU_ARB_LOCK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_locked  <= 1'b0;
         r_lock_id <= 1'b0;
      end else if (w_fire) begin
         r_locked  <= i_lock[w_id];
         r_lock_id <= w_id;
      end else if (r_locked && !i_valid[r_lock_id]) begin
         r_locked  <= 1'b0;
      end
   end
`endif

   assign o_grant = w_grant;
   assign o_ptr   = r_ptr;
   assign o_fire  = w_fire;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one EXE ALU between two requesters with a registered response slot
// and the architectural SR. Optional grant locking: define ALU_ARB_LOCK_EN.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_in1,
   input  logic [NUM_REQ*WIDTH-1:0]   req_in2,
   input  logic [NUM_REQ*4-1:0]       req_cmd,
   input  logic [NUM_REQ-1:0]         req_s,
   input  logic [NUM_REQ-1:0]         req_lock,
   output logic [WIDTH-1:0]           alu_in1,
   output logic [WIDTH-1:0]           alu_in2,
   output logic [3:0]                 alu_cmd,
   output logic                       alu_c,
   input  logic [WIDTH-1:0]           alu_result,
   input  logic [3:0]                 alu_status,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic                       rsp_id,
   output logic [WIDTH-1:0]           rsp_result,
   output logic [3:0]                 rsp_status,
   output logic [3:0]                 sr
);

   logic               r_rsp_valid;
   logic               r_rsp_id;
   logic [WIDTH-1:0]   r_rsp_result;
   logic [3:0]         r_rsp_status;
   logic [3:0]         r_sr;

   logic               w_can_accept;
   logic [NUM_REQ-1:0] w_grant;
   logic               w_ptr;
   logic               w_fire;
   logic               w_sel;

   assign w_can_accept = ~r_rsp_valid | rsp_ready;

   rr_arbiter2 u_arb (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_valid      (req_valid),
      .i_lock       (req_lock),
      .i_can_accept (w_can_accept),
      .o_grant      (w_grant),
      .o_ptr        (w_ptr),
      .o_fire       (w_fire)
   );

   // Idle cycles still present the pointer's requester so the ALU never sees X.
   assign w_sel     = w_grant[1] | (~w_grant[0] & w_ptr);
   assign req_ready = w_grant & {NUM_REQ{w_can_accept}};

   assign alu_in1 = w_sel ? req_in1[2*WIDTH-1:WIDTH] : req_in1[WIDTH-1:0];
   assign alu_in2 = w_sel ? req_in2[2*WIDTH-1:WIDTH] : req_in2[WIDTH-1:0];
   assign alu_cmd = w_sel ? req_cmd[7:4] : req_cmd[3:0];
   assign alu_c   = r_sr[SR_C];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_status <= 4'b0000;
         r_sr         <= 4'b0000;
      end else if (w_fire) begin
         r_rsp_valid  <= 1'b1;
         r_rsp_id     <= w_sel;
         r_rsp_result <= alu_result;
         r_rsp_status <= alu_status;
         if (req_s[w_sel] && cmd_sets_sr(alu_cmd)) r_sr <= alu_status;
      end else if (rsp_ready) begin
         r_rsp_valid  <= 1'b0;
      end
   end

   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign rsp_status = r_rsp_status;
   assign sr         = r_sr;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one EXE-stage ALU between two requesters (R0 = main execute stage, R1 = auxiliary/multi-cycle unit) using round-robin arbitration with a valid/ready handshake. The block drives the ALU operands, command and carry-in combinationally from the granted requester. It registers the result and status into a single response slot, and owns the architectural status register (SR, {Z,C,N,V}), which it updates only when the accepted op has its S bit set.

Parameters:
WIDTH, 32, operand/result width
NUM_REQ, 2, requester count; fixed at 2 and not to be overridden

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  2  per-requester op valid
req_ready  out  2  per-requester accept; op transfers on valid&ready
req_in1  in  2*WIDTH  operand 1; R0 in [WIDTH-1:0]
req_in2  in  2*WIDTH  operand 2
req_cmd  in  8  4-bit EXE command per requester
req_s  in  2  per-requester S bit: update SR
req_lock  in  2  hold grant (used only with ALU_ARB_LOCK_EN)
alu_in1  out  WIDTH  to ALU
alu_in2  out  WIDTH  to ALU
alu_cmd  out  4  to ALU
alu_c  out  1  ALU carry-in = SR.C
alu_result  in  WIDTH  from ALU
alu_status  in  4  from ALU, {Z,C,N,V}
rsp_valid  out  1  response slot full
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that owns the response
rsp_result  out  WIDTH  registered result
rsp_status  out  4  registered ALU status
sr  out  4  status register {Z,C,N,V}

Behaviour:
- Reset (async on rst_n low): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_status=0, sr=0, rr pointer=0. An in-flight response is discarded. No reset-state dependence after rst_n releases.
- can_accept = ~rsp_valid | rsp_ready. Taking a response and issuing a new op in the same cycle is allowed; throughput is 1 op/cycle.
- Grant selection is combinational:
  - Both requesters valid: grant goes to the pointer.
  - One valid: grant goes to that requester.
  - None valid: no grant.
- req_ready[i] = grant[i] & can_accept. It must not depend on req_valid of the other requester beyond arbitration.
- ALU drive:
  - alu_* come from the granted requester.
  - With no grant, alu_* = requester at the pointer. The value is don't-care but must be stable/no X.
  - alu_c = sr[2] always.
- On accept by requester i (latency 1 cycle):
  - rsp_result<=alu_result, rsp_status<=alu_status, rsp_id<=i, rsp_valid<=1.
  - Pointer <= ~i.
  - If req_s[i] and cmd is in {0001,1001,0010,0011,0100,0101,0110,0111,1000}, sr<=alu_status. Otherwise sr holds; this covers cmd 0000 and undefined codes.
- SR is visible to the next accepted op's carry-in on the following cycle. Back-to-back ADC/SBC chains therefore use the updated C with no bubble.
- rsp_valid & rsp_ready with no new accept: rsp_valid<=0. The rsp_* data holds its last value.
- rsp_valid & ~rsp_ready: the slot holds and no req_ready is asserted. Pointer and SR are frozen.
- Requester dropping valid before accept is legal. Nothing changes and the pointer does not move.

Optional Feature:
ALU_ARB_LOCK_EN:
- Defined: a lock is set when requester i is accepted with req_lock[i]=1. While locked, grant is forced to i even if the other requester is valid. The pointer does not advance. The lock clears on an accept from i with req_lock[i]=0, or when req_valid[i] is low for a cycle. Reset clears the lock.
- Undefined: req_lock is ignored (port kept, unconnected internally) and arbitration is pure round-robin.

Decomposition:
- alu_arb_pkg holds:
  - EXE command constants: MOV=0001, MVN=1001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000, NOP=0000.
  - Status bit indices: Z=3, C=2, N=1, V=0.
  - NUM_REQ.
- One sub-module, rr_arbiter2: 2-way round-robin grant plus pointer and lock state. The datapath mux, response slot and SR stay in alu_arbiter. The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then R0 ADD 0xFFFFFFFF+0x00000001 with S=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=0, rsp_status=4'b1100, sr=4'b1100.
- sr.C=1, R1 ADC 5+6 with S=0 -> rsp_result=12, alu_c=1 seen, sr unchanged.
- Both valid every cycle, rsp_ready=1 -> grants alternate R0,R1,R0,R1 starting with R0 after reset, one response per cycle.
- Response pending, rsp_ready=0 for 3 cycles, both valid -> req_ready=00 for 3 cycles, rsp_* stable, sr and pointer unchanged; a single accept resumes in the cycle rsp_ready rises.
- rst_n pulsed low while rsp_valid=1 and sr=4'b0110 -> rsp_valid=0 and sr=0 immediately, without waiting for a clock edge.
- With ALU_ARB_LOCK_EN: R1 SUB with lock=1, then R0 and R1 both valid for 2 more ops with lock=1,1,0 -> R1 granted 3 times, then R0 granted next. Without the macro, the same stimulus alternates.
